// File: rtl/decode_forward_pkg.sv
// Shared opcode constants and immediate-format classification for the
// decode/forward stage.
package decode_forward_pkg;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_type_e;

   function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
      imm_type_e t;
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR: t = IMM_I;
         OP_STORE:                 t = IMM_S;
         OP_BRANCH:                t = IMM_B;
         OP_LUI, OP_AUIPC:         t = IMM_U;
         OP_JAL:                   t = IMM_J;
         default:                  t = IMM_NONE;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/decode_operand_select.sv
// Resolves one source operand against the in-flight producers; the nearest
// matching producer wins and its pending flag is reported.
module decode_operand_select #(
   parameter int DATA_WIDTH = 32,
   parameter int FWD_STAGES = 3,
   parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
   input  logic [4:0]                       addr,
   input  logic [DATA_WIDTH-1:0]            rf_data,
   input  logic [FWD_STAGES-1:0]            fwd_valid,
   input  logic [5*FWD_STAGES-1:0]          fwd_rd,
   input  logic [DATA_WIDTH*FWD_STAGES-1:0] fwd_data,
   input  logic [FWD_STAGES-1:0]            fwd_pending,
   output logic [DATA_WIDTH-1:0]            data,
   output logic [SEL_W-1:0]                 sel,
   output logic                             pending
);

   import decode_forward_pkg::*;

   logic found;

   always_comb begin
      data    = rf_data;
      sel     = '0;
      pending = 1'b0;
      found   = 1'b0;
      if (addr == 5'd0) begin
         data = '0;
      end else begin
         // Scan from nearest to oldest; the first hit locks out older ones.
         for (int unsigned i = 0; i < FWD_STAGES; i++) begin
            if (!found && fwd_valid[i] && (fwd_rd[5*i +: 5] == addr)) begin
               found   = 1'b1;
               data    = fwd_data[DATA_WIDTH*i +: DATA_WIDTH];
               sel     = SEL_W'(i + 1);
               pending = fwd_pending[i];
            end
         end
      end
   end

endmodule

// File: rtl/decode_forward_stage.sv
// Decode stage: field split, immediate generation, operand forwarding with
// load-use hazard detection, and a valid/ready ID/EX register.
module decode_forward_stage #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20,
   parameter int FWD_STAGES   = 3,
   parameter int SEL_W        = $clog2(FWD_STAGES + 1),
   parameter int CNT_W        = 16
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [ADDRESS_BITS-1:0]          in_pc,
   input  logic [31:0]                      in_instruction,
   output logic [4:0]                       rf_rs1_addr,
   output logic [4:0]                       rf_rs2_addr,
   input  logic [DATA_WIDTH-1:0]            rf_rs1_data,
   input  logic [DATA_WIDTH-1:0]            rf_rs2_data,
   input  logic [FWD_STAGES-1:0]            fwd_valid,
   input  logic [5*FWD_STAGES-1:0]          fwd_rd,
   input  logic [DATA_WIDTH*FWD_STAGES-1:0] fwd_data,
   input  logic [FWD_STAGES-1:0]            fwd_pending,
   input  logic                             flush,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ADDRESS_BITS-1:0]          out_pc,
   output logic [DATA_WIDTH-1:0]            out_rs1_data,
   output logic [DATA_WIDTH-1:0]            out_rs2_data,
   output logic [SEL_W-1:0]                 out_rs1_sel,
   output logic [SEL_W-1:0]                 out_rs2_sel,
   output logic [4:0]                       out_rd,
   output logic [6:0]                       out_opcode,
   output logic [2:0]                       out_funct3,
   output logic [6:0]                       out_funct7,
   output logic [31:0]                      out_imm,
   output logic [CNT_W-1:0]                 hazard_count
);

   import decode_forward_pkg::*;

   logic [6:0]            opcode;
   logic [31:0]           imm;
   logic [DATA_WIDTH-1:0] rs1_data, rs2_data;
   logic [SEL_W-1:0]      rs1_sel, rs2_sel;
   logic                  rs1_pending, rs2_pending;
   logic                  hazard;

   assign opcode      = in_instruction[6:0];
   assign rf_rs1_addr = in_instruction[19:15];
   assign rf_rs2_addr = in_instruction[24:20];

   always_comb begin
      imm = '0;
      case (imm_type_of(opcode))
         IMM_I: imm = {{20{in_instruction[31]}}, in_instruction[31:20]};
         IMM_S: imm = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
         IMM_B: imm = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                       in_instruction[30:25], in_instruction[11:8], 1'b0};
         IMM_U: imm = {in_instruction[31:12], 12'b0};
         IMM_J: imm = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                       in_instruction[20], in_instruction[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

   decode_operand_select #(
      .DATA_WIDTH (DATA_WIDTH),
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (SEL_W)
   ) u_rs1_sel (
      .addr        (rf_rs1_addr),
      .rf_data     (rf_rs1_data),
      .fwd_valid   (fwd_valid),
      .fwd_rd      (fwd_rd),
      .fwd_data    (fwd_data),
      .fwd_pending (fwd_pending),
      .data        (rs1_data),
      .sel         (rs1_sel),
      .pending     (rs1_pending)
   );

   decode_operand_select #(
      .DATA_WIDTH (DATA_WIDTH),
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (SEL_W)
   ) u_rs2_sel (
      .addr        (rf_rs2_addr),
      .rf_data     (rf_rs2_data),
      .fwd_valid   (fwd_valid),
      .fwd_rd      (fwd_rd),
      .fwd_data    (fwd_data),
      .fwd_pending (fwd_pending),
      .data        (rs2_data),
      .sel         (rs2_sel),
      .pending     (rs2_pending)
   );

   assign hazard   = in_valid && (rs1_pending || rs2_pending);
   assign in_ready = !flush && !hazard && (!out_valid || out_ready);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_rs1_data <= '0;
         out_rs2_data <= '0;
         out_rs1_sel  <= '0;
         out_rs2_sel  <= '0;
         out_rd       <= '0;
         out_opcode   <= '0;
         out_funct3   <= '0;
         out_funct7   <= '0;
         out_imm      <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid    <= 1'b1;
         out_pc       <= in_pc;
         out_rs1_data <= rs1_data;
         out_rs2_data <= rs2_data;
         out_rs1_sel  <= rs1_sel;
         out_rs2_sel  <= rs2_sel;
         out_rd       <= in_instruction[11:7];
         out_opcode   <= opcode;
         out_funct3   <= in_instruction[14:12];
         out_funct7   <= in_instruction[31:25];
         out_imm      <= imm;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hazard_count <= '0;
      end else if (hazard && !flush && (hazard_count != '1)) begin
         hazard_count <= hazard_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decode_forward_stage.sv
// Self-checking bench for decode_forward_stage: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_decode_forward_stage;

   localparam int DW = 32;
   localparam int AB = 20;
   localparam int FS = 3;
   localparam int SW = $clog2(FS + 1);
   localparam int CW = 16;

   logic           clock = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [AB-1:0]  in_pc;
   logic [31:0]    in_instruction;
   logic [4:0]     rf_rs1_addr, rf_rs2_addr;
   logic [DW-1:0]  rf_rs1_data, rf_rs2_data;
   logic [FS-1:0]  fwd_valid, fwd_pending;
   logic [5*FS-1:0]  fwd_rd;
   logic [DW*FS-1:0] fwd_data;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [AB-1:0]  out_pc;
   logic [DW-1:0]  out_rs1_data, out_rs2_data;
   logic [SW-1:0]  out_rs1_sel, out_rs2_sel;
   logic [4:0]     out_rd;
   logic [6:0]     out_opcode;
   logic [2:0]     out_funct3;
   logic [6:0]     out_funct7;
   logic [31:0]    out_imm;
   logic [CW-1:0]  hazard_count;

   logic [4:0]     f_rd   [FS];
   logic [DW-1:0]  f_data [FS];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   always_comb begin
      for (int i = 0; i < FS; i++) begin
         fwd_rd[5*i +: 5]    = f_rd[i];
         fwd_data[DW*i +: DW] = f_data[i];
      end
   end

   decode_forward_stage #(
      .DATA_WIDTH   (DW),
      .ADDRESS_BITS (AB),
      .FWD_STAGES   (FS),
      .SEL_W        (SW),
      .CNT_W        (CW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pc          (in_pc),
      .in_instruction (in_instruction),
      .rf_rs1_addr    (rf_rs1_addr),
      .rf_rs2_addr    (rf_rs2_addr),
      .rf_rs1_data    (rf_rs1_data),
      .rf_rs2_data    (rf_rs2_data),
      .fwd_valid      (fwd_valid),
      .fwd_rd         (fwd_rd),
      .fwd_data       (fwd_data),
      .fwd_pending    (fwd_pending),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_rs1_data   (out_rs1_data),
      .out_rs2_data   (out_rs2_data),
      .out_rs1_sel    (out_rs1_sel),
      .out_rs2_sel    (out_rs2_sel),
      .out_rd         (out_rd),
      .out_opcode     (out_opcode),
      .out_funct3     (out_funct3),
      .out_funct7     (out_funct7),
      .out_imm        (out_imm),
      .hazard_count   (hazard_count)
   );

   // Immediate value computed as a signed integer from the RV32I field weights.
   function automatic logic [31:0] ref_imm(input logic [31:0] ins);
      longint v = 0;
      case (ins[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: begin
            v = longint'(ins[30:20]) - (ins[31] ? 2048 : 0);
         end
         7'b0100011: begin
            v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 2048 : 0);
         end
         7'b1100011: begin
            v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
              + longint'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
         end
         7'b0110111, 7'b0010111: begin
            v = longint'(ins[31:12]) * 4096;
         end
         7'b1101111: begin
            v = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048
              + longint'(ins[19:12]) * 4096 - (ins[31] ? 1048576 : 0);
         end
         default: v = 0;
      endcase
      return v[31:0];
   endfunction

   function automatic void ref_operand(input logic [4:0] addr, input logic [DW-1:0] rf,
                                       output logic [DW-1:0] d, output logic [SW-1:0] s,
                                       output logic p);
      d = rf; s = '0; p = 1'b0;
      if (addr == 5'd0) begin
         d = '0;
         return;
      end
      for (int i = 0; i < FS; i++) begin
         if (fwd_valid[i] && f_rd[i] == addr) begin
            d = f_data[i]; s = SW'(i + 1); p = fwd_pending[i];
            return;
         end
      end
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      in_valid = 1'b0; in_pc = '0; in_instruction = 32'h0000_0013;
      rf_rs1_data = '0; rf_rs2_data = '0;
      fwd_valid = '0; fwd_pending = '0; flush = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < FS; i++) begin
         f_rd[i] = '0; f_data[i] = '0;
      end
   endtask

   task automatic do_reset;
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || out_pc !== '0 || out_imm !== '0 || out_rs1_data !== '0
          || out_rd !== '0 || hazard_count !== '0) begin
         errors++;
         $display("FAIL reset_state: valid=%b pc=%h imm=%h rs1=%h rd=%h cnt=%h, required all zero",
                  out_valid, out_pc, out_imm, out_rs1_data, out_rd, hazard_count);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_addi;
      do_reset();
      in_valid = 1'b1; in_pc = 20'h00100; in_instruction = 32'h0070_8293; rf_rs1_data = 32'd10;
      #1;
      checks++;
      if (rf_rs1_addr !== 5'd1 || rf_rs2_addr !== 5'd7 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL addi_comb: rs1_addr=%0d rs2_addr=%0d ready=%b required 1 7 1",
                  rf_rs1_addr, rf_rs2_addr, in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_rs1_sel !== '0 || out_imm !== 32'd7 || out_rd !== 5'd5
          || out_rs1_data !== 32'd10 || out_opcode !== 7'b0010011 || out_pc !== 20'h00100) begin
         errors++;
         $display("FAIL addi_out: valid=%b sel=%0d imm=%h rd=%0d rs1=%h op=%b pc=%h",
                  out_valid, out_rs1_sel, out_imm, out_rd, out_rs1_data, out_opcode, out_pc);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL addi_drain: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_forward_priority;
      do_reset();
      in_valid = 1'b1; in_instruction = 32'h0020_81B3;
      rf_rs1_data = 32'h1111; rf_rs2_data = 32'h2222;
      fwd_valid = 3'b111;
      f_rd[0] = 5'd1; f_data[0] = 32'hAAAA;
      f_rd[1] = 5'd2; f_data[1] = 32'h0055;
      f_rd[2] = 5'd1; f_data[2] = 32'hBBBB;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_rs1_data !== 32'hAAAA || out_rs1_sel !== SW'(1)) begin
         errors++;
         $display("FAIL fwd_rs1_nearest: data=%h sel=%0d required aaaa 1", out_rs1_data, out_rs1_sel);
      end
      checks++;
      if (out_rs2_data !== 32'h0055 || out_rs2_sel !== SW'(2) || out_rd !== 5'd3) begin
         errors++;
         $display("FAIL fwd_rs2: data=%h sel=%0d rd=%0d required 55 2 3", out_rs2_data, out_rs2_sel, out_rd);
      end
      // x0 source is never forwarded
      fwd_valid = 3'b001; f_rd[0] = 5'd0; f_data[0] = 32'hFFFF;
      in_valid = 1'b1; in_instruction = 32'h0010_0293; rf_rs1_data = 32'h77;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_rs1_data !== '0 || out_rs1_sel !== '0 || out_imm !== 32'd1) begin
         errors++;
         $display("FAIL x0_source: data=%h sel=%0d imm=%h required 0 0 1", out_rs1_data, out_rs1_sel, out_imm);
      end
   endtask

   task automatic test_load_use;
      do_reset();
      in_valid = 1'b1; in_pc = 20'h00200; in_instruction = 32'h0020_81B3;
      fwd_valid = 3'b101; fwd_pending = 3'b001;
      f_rd[0] = 5'd1; f_data[0] = 32'hDEAD;
      f_rd[2] = 5'd1; f_data[2] = 32'h0BAD;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_use_ready: cycle %0d in_ready=%b required 0", c, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: cycle %0d out_valid=%b required 0", c, out_valid);
         end
      end
      checks++;
      if (hazard_count !== CW'(3)) begin
         errors++;
         $display("FAIL load_use_count: hazard_count=%0d required 3", hazard_count);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (hazard_count !== CW'(3)) begin
         errors++;
         $display("FAIL flush_no_count: hazard_count=%0d required 3", hazard_count);
      end
      fwd_pending = '0; f_data[0] = 32'h1234;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL load_use_release: in_ready=%b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_rs1_data !== 32'h1234 || out_rs1_sel !== SW'(1)) begin
         errors++;
         $display("FAIL load_use_accept: valid=%b data=%h sel=%0d required 1 1234 1",
                  out_valid, out_rs1_data, out_rs1_sel);
      end
   endtask

   task automatic test_stall_flush;
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 20'h00AAA; in_instruction = 32'h0070_8293;
      tick();
      in_pc = 20'h00BBB; in_instruction = 32'h0010_0293;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_ready: in_ready=%b required 0", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 20'h00AAA || out_imm !== 32'd7) begin
         errors++;
         $display("FAIL stall_hold: valid=%b pc=%h imm=%h required 1 aaa 7", out_valid, out_pc, out_imm);
      end
      flush = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
      end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_drop: out_valid=%b required 0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_no_accept: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 20'h12345; in_instruction = 32'h0070_8293;
      tick();
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_pc !== '0 || out_imm !== '0) begin
         errors++;
         $display("FAIL reset_mid: valid=%b pc=%h imm=%h required 0 0 0", out_valid, out_pc, out_imm);
      end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_random;
      logic [6:0]     ops [10];
      logic           m_valid;
      logic [CW-1:0]  m_cnt;
      logic [141:0]   m_fields;
      logic [DW-1:0]  d1, d2;
      logic [SW-1:0]  s1, s2;
      logic           p1, p2, hz, rdy;
      logic [31:0]    ins;
      ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
              7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1110011};
      do_reset();
      m_valid = 1'b0; m_cnt = '0; m_fields = '0;
      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         ins[6:0]   = ops[$urandom_range(0, 9)];
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         in_instruction = ins;
         in_valid = ($urandom_range(0, 3) != 0);
         in_pc = AB'($urandom);
         rf_rs1_data = $urandom; rf_rs2_data = $urandom;
         for (int i = 0; i < FS; i++) begin
            f_rd[i] = 5'($urandom_range(0, 7));
            f_data[i] = $urandom;
            fwd_valid[i] = $urandom_range(0, 1) == 1;
            fwd_pending[i] = $urandom_range(0, 5) == 0;
         end
         flush = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         ref_operand(ins[19:15], rf_rs1_data, d1, s1, p1);
         ref_operand(ins[24:20], rf_rs2_data, d2, s2, p2);
         hz  = in_valid && (p1 || p2);
         rdy = !flush && !hz && (!m_valid || out_ready);
         checks++;
         if (in_ready !== rdy) begin
            errors++;
            $display("FAIL rand_ready: cycle %0d in_ready=%b required %b", n, in_ready, rdy);
         end
         if (flush) begin
            m_valid = 1'b0;
         end else if (in_valid && rdy) begin
            m_valid = 1'b1;
            m_fields = {in_pc, d1, d2, s1, s2, ins[11:7], ins[6:0], ins[14:12], ins[31:25], ref_imm(ins)};
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         if (hz && !flush && m_cnt != '1) m_cnt = m_cnt + 1'b1;
         tick();
         checks++;
         if (out_valid !== m_valid || hazard_count !== m_cnt) begin
            errors++;
            $display("FAIL rand_state: cycle %0d valid=%b cnt=%0d required %b %0d",
                     n, out_valid, hazard_count, m_valid, m_cnt);
         end
         if (m_valid) begin
            checks++;
            if ({out_pc, out_rs1_data, out_rs2_data, out_rs1_sel, out_rs2_sel, out_rd, out_opcode,
                 out_funct3, out_funct7, out_imm} !== m_fields) begin
               errors++;
               $display("FAIL rand_fields: cycle %0d got %h required %h", n,
                        {out_pc, out_rs1_data, out_rs2_data, out_rs1_sel, out_rs2_sel, out_rd,
                         out_opcode, out_funct3, out_funct7, out_imm}, m_fields);
            end
         end
      end
   endtask

   task automatic test_saturation;
      do_reset();
      in_valid = 1'b1; in_instruction = 32'h0020_81B3;
      fwd_valid = 3'b001; fwd_pending = 3'b001; f_rd[0] = 5'd1;
      for (int c = 0; c < (1 << CW) - 1; c++) tick();
      checks++;
      if (hazard_count !== '1) begin
         errors++;
         $display("FAIL sat_reach: hazard_count=%h required all ones", hazard_count);
      end
      for (int c = 0; c < 6; c++) tick();
      checks++;
      if (hazard_count !== '1) begin
         errors++;
         $display("FAIL sat_hold: hazard_count=%h required all ones", hazard_count);
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_addi();
      test_forward_priority();
      test_load_use();
      test_stall_flush();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
